// File: rtl/mapper_sram_arbiter_pkg.sv
// Shared types and constants for the mapper SRAM arbiter: FSM states, owner
// encoding and the CPU physical address layout.
package mapper_pkg;

  localparam int SEG_W     = 5;
  localparam int PAGE_BITS = 14;
  localparam int ADDR_W    = SEG_W + PAGE_BITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    CPU = 1'b0,
    AUX = 1'b1
  } owner_t;

  // CPU physical address: mapper segment on top of the 16 KB page offset.
  function automatic logic [ADDR_W-1:0] cpu_phys(input logic [SEG_W-1:0]     seg,
                                                 input logic [PAGE_BITS-1:0] a);
    return {seg, a};
  endfunction

endpackage

// File: rtl/mapper_sram_arbiter_if.sv
// Requester and SRAM-side signal bundle for the mapper SRAM arbiter.
interface mapper_sram_arbiter_if;
  import mapper_pkg::*;

  logic                 CPU_REQ;
  logic                 CPU_WE;
  logic [SEG_W-1:0]     CPU_SEG;
  logic [PAGE_BITS-1:0] CPU_A;
  logic [7:0]           CPU_DIN;
  logic [7:0]           CPU_DOUT;
  logic                 CPU_ACK;
  logic                 CPU_WAITb;

  logic                 AUX_REQ;
  logic                 AUX_WE;
  logic [ADDR_W-1:0]    AUX_ADDR;
  logic [7:0]           AUX_DIN;
  logic [7:0]           AUX_DOUT;
  logic                 AUX_ACK;

  logic [ADDR_W-1:0]    SRAM_A;
  logic [7:0]           SRAM_DO;
  logic [7:0]           SRAM_DI;
  logic                 SRAM_DOE;
  logic                 SRAM_CEb;
  logic                 SRAM_OEb;
  logic                 SRAM_WEb;

  modport master (
    output CPU_REQ, CPU_WE, CPU_SEG, CPU_A, CPU_DIN,
    input  CPU_DOUT, CPU_ACK, CPU_WAITb,
    output AUX_REQ, AUX_WE, AUX_ADDR, AUX_DIN,
    input  AUX_DOUT, AUX_ACK,
    input  SRAM_A, SRAM_DO, SRAM_DOE, SRAM_CEb, SRAM_OEb, SRAM_WEb,
    output SRAM_DI
  );

  modport slave (
    input  CPU_REQ, CPU_WE, CPU_SEG, CPU_A, CPU_DIN,
    output CPU_DOUT, CPU_ACK, CPU_WAITb,
    input  AUX_REQ, AUX_WE, AUX_ADDR, AUX_DIN,
    output AUX_DOUT, AUX_ACK,
    output SRAM_A, SRAM_DO, SRAM_DOE, SRAM_CEb, SRAM_OEb, SRAM_WEb,
    input  SRAM_DI
  );

endinterface

// File: rtl/mapper_sram_arbiter_rr_arb2.sv
// Two-input round-robin grant; last_grant only moves when a grant is taken.
module rr_arb2
  import mapper_pkg::*;
(
  input  logic   CLK,
  input  logic   RSTb,
  input  logic   req_cpu,
  input  logic   req_aux,
  input  logic   en,
  output logic   gnt_valid,
  output owner_t gnt_owner
);

  owner_t last_q;

  always_comb begin
    gnt_valid = req_cpu | req_aux;
    gnt_owner = CPU;
    if (req_cpu && req_aux)
      gnt_owner = (last_q == CPU) ? AUX : CPU;
    else if (req_aux)
      gnt_owner = AUX;
  end

  // Reset to AUX so the CPU wins the first tie.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb)
      last_q <= AUX;
    else if (en && gnt_valid)
      last_q <= gnt_owner;
  end

endmodule

// File: rtl/mapper_sram_arbiter.sv
// Shares the mapper SRAM between the Z80 and an auxiliary port; generates the
// SRAM strobes, Z80 wait-states and per-owner registered read data.
//
// state  | meaning
// IDLE   | sample requests, latch the granted transfer
// ACCESS | strobes active for WAIT_CYC cycles, read data captured on the last
// DONE   | strobes off, owner ACK pulses for this cycle only
module mapper_sram_arbiter
  import mapper_pkg::*;
#(
  parameter int WAIT_CYC = 2
) (
  input  logic                 CLK,
  input  logic                 RSTb,
  mapper_sram_arbiter_if.slave bus
);

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYC - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  owner_t            owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] sram_a_q;
  logic [7:0]        sram_do_q;
  logic [7:0]        cpu_dout_q;
  logic [7:0]        aux_dout_q;

  logic   gnt_valid;
  owner_t gnt_owner;
  logic   last_cyc;
  logic   ceb, oeb, web, doe, ack_cpu, ack_aux;

  rr_arb2 u_arb (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .req_cpu   (bus.CPU_REQ),
    .req_aux   (bus.AUX_REQ),
    .en        (state_q == IDLE),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  assign last_cyc = (cnt_q == LAST_CNT);

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ceb     = 1'b1;
    oeb     = 1'b1;
    web     = 1'b1;
    doe     = 1'b0;
    ack_cpu = 1'b0;
    ack_aux = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) state_d = ACCESS;
      end
      ACCESS: begin
        ceb = 1'b0;
        if (we_q) begin
          doe = 1'b1;
          // WEb releases one cycle early so data/address hold past the strobe.
          web = ~(cnt_q < LAST_CNT);
        end else begin
          oeb = 1'b0;
        end
        if (last_cyc) state_d = DONE;
      end
      DONE: begin
        ack_cpu = (owner_q == CPU);
        ack_aux = (owner_q == AUX);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      cnt_q      <= '0;
      owner_q    <= AUX;
      we_q       <= 1'b0;
      sram_a_q   <= '0;
      sram_do_q  <= '0;
      cpu_dout_q <= '0;
      aux_dout_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            owner_q <= gnt_owner;
            cnt_q   <= '0;
            if (gnt_owner == CPU) begin
              we_q      <= bus.CPU_WE;
              sram_a_q  <= cpu_phys(bus.CPU_SEG, bus.CPU_A);
              sram_do_q <= bus.CPU_DIN;
            end else begin
              we_q      <= bus.AUX_WE;
              sram_a_q  <= bus.AUX_ADDR;
              sram_do_q <= bus.AUX_DIN;
            end
          end
        end
        ACCESS: begin
          cnt_q <= cnt_q + 4'd1;
          if (last_cyc && !we_q) begin
            if (owner_q == CPU) cpu_dout_q <= bus.SRAM_DI;
            else                aux_dout_q <= bus.SRAM_DI;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.SRAM_A    = sram_a_q;
  assign bus.SRAM_DO   = sram_do_q;
  assign bus.SRAM_DOE  = doe;
  assign bus.SRAM_CEb  = ceb;
  assign bus.SRAM_OEb  = oeb;
  assign bus.SRAM_WEb  = web;
  assign bus.CPU_ACK   = ack_cpu;
  assign bus.AUX_ACK   = ack_aux;
  assign bus.CPU_DOUT  = cpu_dout_q;
  assign bus.AUX_DOUT  = aux_dout_q;
  assign bus.CPU_WAITb = ~(bus.CPU_REQ & ~ack_cpu);

endmodule

// File: tb/tb_mapper_sram_arbiter.sv
// Directed bench for mapper_sram_arbiter: a WAIT_CYC=2 instance checked by a
// scoreboard of expected completions, and a WAIT_CYC=3 instance for strobe widths.
module tb_mapper_sram_arbiter;
  import mapper_pkg::*;

  typedef struct packed {
    logic        owner;
    logic        we;
    logic [18:0] addr;
    logic [7:0]  data;
  } exp_t;

  logic CLK  = 1'b0;
  logic RSTb = 1'b0;
  always #5 CLK = ~CLK;

  mapper_sram_arbiter_if bus2 ();
  mapper_sram_arbiter_if bus3 ();

  mapper_sram_arbiter #(.WAIT_CYC(2)) u_dut2 (.CLK(CLK), .RSTb(RSTb), .bus(bus2));
  mapper_sram_arbiter #(.WAIT_CYC(3)) u_dut3 (.CLK(CLK), .RSTb(RSTb), .bus(bus3));

  logic [7:0] mem2 [0:524287];
  logic [7:0] mem3 [0:524287];

  assign bus2.SRAM_DI = mem2[bus2.SRAM_A];
  assign bus3.SRAM_DI = mem3[bus3.SRAM_A];

  always @(posedge CLK) begin
    if (!bus2.SRAM_CEb && !bus2.SRAM_WEb) mem2[bus2.SRAM_A] = bus2.SRAM_DO;
    if (!bus3.SRAM_CEb && !bus3.SRAM_WEb) mem3[bus3.SRAM_A] = bus3.SRAM_DO;
  end

  int   total = 0;
  int   bad   = 0;
  int   ack_cnt = 0;
  exp_t sbq[$];
  logic prev_cack = 1'b0;
  logic prev_aack = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every ACK of the WAIT_CYC=2 instance retires the oldest expectation.
  always @(negedge CLK) begin
    if (RSTb) begin
      if (prev_cack) chk("cpu_ack_width", 32'(bus2.CPU_ACK), 32'd0);
      if (prev_aack) chk("aux_ack_width", 32'(bus2.AUX_ACK), 32'd0);
      if (bus2.CPU_ACK || bus2.AUX_ACK) begin
        exp_t e;
        ack_cnt++;
        chk("ack_expected", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("both_ack", 32'(bus2.CPU_ACK & bus2.AUX_ACK), 32'd0);
          chk("owner", 32'(bus2.AUX_ACK), 32'(e.owner));
          chk("addr", 32'(bus2.SRAM_A), 32'(e.addr));
          if (!e.we)
            chk("rdata", 32'(e.owner ? bus2.AUX_DOUT : bus2.CPU_DOUT), 32'(e.data));
          else
            chk("wdata", 32'(mem2[e.addr]), 32'(e.data));
        end
      end
    end
    prev_cack = bus2.CPU_ACK & RSTb;
    prev_aack = bus2.AUX_ACK & RSTb;
  end

  task automatic wait_acks(input int target, input int budget);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      @(posedge CLK);
      n++;
    end
    chk("ack_timeout", 32'(ack_cnt >= target), 32'd1);
    #1;
  endtask

  task automatic aux3_xfer(input logic we, input logic [18:0] addr, input logic [7:0] din,
                           output int doe_n, output int web_n, output int oe_n,
                           output int ack_n, output int cack_n);
    doe_n = 0; web_n = 0; oe_n = 0; ack_n = 0; cack_n = 0;
    bus3.AUX_REQ  = 1'b1;
    bus3.AUX_WE   = we;
    bus3.AUX_ADDR = addr;
    bus3.AUX_DIN  = din;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      doe_n  += int'(bus3.SRAM_DOE);
      web_n  += int'(!bus3.SRAM_WEb);
      oe_n   += int'(!bus3.SRAM_OEb);
      ack_n  += int'(bus3.AUX_ACK);
      cack_n += int'(bus3.CPU_ACK);
      if (bus3.AUX_ACK) begin
        @(posedge CLK);
        #1 bus3.AUX_REQ = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int doe_n, web_n, oe_n, ack_n, cack_n, cyc, cack, base;
    int acks[$];

    for (int i = 0; i < 524288; i++) begin
      mem2[i] = 8'h00;
      mem3[i] = 8'h00;
    end
    mem2[19'h0C010] = 8'hA5;
    mem2[19'h08100] = 8'h11;
    mem2[19'h40000] = 8'h22;
    mem2[19'h04200] = 8'h3C;
    mem3[19'h00123] = 8'hC3;

    bus2.CPU_REQ = 0; bus2.CPU_WE = 0; bus2.CPU_SEG = '0; bus2.CPU_A = '0; bus2.CPU_DIN = '0;
    bus2.AUX_REQ = 0; bus2.AUX_WE = 0; bus2.AUX_ADDR = '0; bus2.AUX_DIN = '0;
    bus3.CPU_REQ = 0; bus3.CPU_WE = 0; bus3.CPU_SEG = '0; bus3.CPU_A = '0; bus3.CPU_DIN = '0;
    bus3.AUX_REQ = 0; bus3.AUX_WE = 0; bus3.AUX_ADDR = '0; bus3.AUX_DIN = '0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_ceb", 32'(bus2.SRAM_CEb), 32'd1);
    chk("rst_oeb", 32'(bus2.SRAM_OEb), 32'd1);
    chk("rst_web", 32'(bus2.SRAM_WEb), 32'd1);
    chk("rst_doe", 32'(bus2.SRAM_DOE), 32'd0);
    chk("rst_a", 32'(bus2.SRAM_A), 32'd0);
    chk("rst_do", 32'(bus2.SRAM_DO), 32'd0);
    chk("rst_acks", 32'({bus2.CPU_ACK, bus2.AUX_ACK}), 32'd0);
    chk("rst_douts", 32'({bus2.CPU_DOUT, bus2.AUX_DOUT}), 32'd0);
    chk("rst_waitb", 32'(bus2.CPU_WAITb), 32'd1);
    RSTb = 1'b1;

    // CPU read {5'h03, 14'h0010}
    @(posedge CLK); #1;
    bus2.CPU_REQ = 1; bus2.CPU_WE = 0; bus2.CPU_SEG = 5'h03; bus2.CPU_A = 14'h0010;
    sbq.push_back('{owner: 1'b0, we: 1'b0, addr: 19'h0C010, data: 8'hA5});
    #1 chk("rd_waitb_req", 32'(bus2.CPU_WAITb), 32'd0);
    @(posedge CLK);
    @(negedge CLK);
    chk("rd_a", 32'(bus2.SRAM_A), 32'h0C010);
    chk("rd_oe_c0", 32'({bus2.SRAM_CEb, bus2.SRAM_OEb, bus2.SRAM_WEb, bus2.SRAM_DOE}), 32'b0010);
    chk("rd_ack_c0", 32'(bus2.CPU_ACK), 32'd0);
    chk("rd_waitb_c0", 32'(bus2.CPU_WAITb), 32'd0);
    @(negedge CLK);
    chk("rd_oe_c1", 32'(bus2.SRAM_OEb), 32'd0);
    chk("rd_waitb_c1", 32'(bus2.CPU_WAITb), 32'd0);
    @(negedge CLK);
    chk("rd_ack_c2", 32'(bus2.CPU_ACK), 32'd1);
    chk("rd_oe_done", 32'(bus2.SRAM_OEb), 32'd1);
    chk("rd_waitb_ack", 32'(bus2.CPU_WAITb), 32'd1);
    chk("rd_dout", 32'(bus2.CPU_DOUT), 32'hA5);
    @(posedge CLK); #1 bus2.CPU_REQ = 0;
    @(negedge CLK);
    chk("rd_ack_after", 32'(bus2.CPU_ACK), 32'd0);
    chk("rd_a_held", 32'(bus2.SRAM_A), 32'h0C010);

    // WAIT_CYC=3 instance: AUX read to load DOUT, then AUX write of 8'h5A to 19'h7FFFF
    @(posedge CLK); #1;
    aux3_xfer(1'b0, 19'h00123, 8'h00, doe_n, web_n, oe_n, ack_n, cack_n);
    chk("w3_rd_oe", 32'(oe_n), 32'd3);
    chk("w3_rd_dout", 32'(bus3.AUX_DOUT), 32'hC3);
    @(posedge CLK); #1;
    aux3_xfer(1'b1, 19'h7FFFF, 8'h5A, doe_n, web_n, oe_n, ack_n, cack_n);
    chk("w3_doe", 32'(doe_n), 32'd3);
    chk("w3_web", 32'(web_n), 32'd2);
    chk("w3_oe", 32'(oe_n), 32'd0);
    chk("w3_ack", 32'(ack_n), 32'd1);
    chk("w3_cpu_ack", 32'(cack_n), 32'd0);
    chk("w3_mem", 32'(mem3[19'h7FFFF]), 32'h5A);
    chk("w3_dout_kept", 32'(bus3.AUX_DOUT), 32'hC3);

    // Simultaneous requests right after reset: CPU, AUX, CPU, AUX
    @(posedge CLK); #1 RSTb = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTb = 1'b1;
    @(posedge CLK); #1;
    bus2.CPU_REQ = 1; bus2.CPU_WE = 0; bus2.CPU_SEG = 5'h02; bus2.CPU_A = 14'h0100;
    bus2.AUX_REQ = 1; bus2.AUX_WE = 0; bus2.AUX_ADDR = 19'h40000;
    for (int k = 0; k < 2; k++) begin
      sbq.push_back('{owner: 1'b0, we: 1'b0, addr: 19'h08100, data: 8'h11});
      sbq.push_back('{owner: 1'b1, we: 1'b0, addr: 19'h40000, data: 8'h22});
    end
    base = ack_cnt;
    wait_acks(base + 4, 40);
    bus2.CPU_REQ = 0; bus2.AUX_REQ = 0;

    // AUX held, CPU idle: back-to-back AUX transfers every WAIT_CYC+2 cycles
    @(posedge CLK); #1;
    bus2.AUX_REQ = 1; bus2.AUX_WE = 0; bus2.AUX_ADDR = 19'h40000;
    for (int k = 0; k < 3; k++)
      sbq.push_back('{owner: 1'b1, we: 1'b0, addr: 19'h40000, data: 8'h22});
    cyc = 0; cack = 0;
    while (acks.size() < 3 && cyc < 40) begin
      @(negedge CLK);
      cyc++;
      if (bus2.AUX_ACK) acks.push_back(cyc);
      if (bus2.CPU_ACK) cack++;
    end
    @(posedge CLK); #1 bus2.AUX_REQ = 0;
    chk("stream_acks", 32'(acks.size()), 32'd3);
    if (acks.size() == 3) begin
      chk("stream_gap1", 32'(acks[1] - acks[0]), 32'd4);
      chk("stream_gap2", 32'(acks[2] - acks[1]), 32'd4);
    end
    chk("stream_no_cpu", 32'(cack), 32'd0);

    // Reset in the middle of a CPU write access
    @(posedge CLK); #1;
    bus2.CPU_REQ = 1; bus2.CPU_WE = 1; bus2.CPU_SEG = 5'h00; bus2.CPU_A = 14'h0055; bus2.CPU_DIN = 8'h77;
    @(posedge CLK);
    @(negedge CLK);
    chk("mid_doe", 32'(bus2.SRAM_DOE), 32'd1);
    chk("mid_web", 32'(bus2.SRAM_WEb), 32'd0);
    #1 RSTb = 1'b0; bus2.CPU_REQ = 0;
    #1;
    chk("mid_strobes", 32'({bus2.SRAM_CEb, bus2.SRAM_OEb, bus2.SRAM_WEb}), 32'b111);
    chk("mid_doe_off", 32'(bus2.SRAM_DOE), 32'd0);
    chk("mid_a_clr", 32'(bus2.SRAM_A), 32'd0);
    cack = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      cack += int'(bus2.CPU_ACK) + int'(bus2.AUX_ACK);
    end
    chk("mid_no_ack", 32'(cack), 32'd0);
    RSTb = 1'b1;
    @(posedge CLK); #1;
    bus2.CPU_REQ = 1; bus2.CPU_WE = 0; bus2.CPU_SEG = 5'h02; bus2.CPU_A = 14'h0100;
    bus2.AUX_REQ = 1; bus2.AUX_WE = 0; bus2.AUX_ADDR = 19'h40000;
    sbq.push_back('{owner: 1'b0, we: 1'b0, addr: 19'h08100, data: 8'h11});
    base = ack_cnt;
    wait_acks(base + 1, 20);
    bus2.CPU_REQ = 0; bus2.AUX_REQ = 0;

    // Segment change during ACCESS must not move the latched address
    @(posedge CLK); #1;
    bus2.CPU_REQ = 1; bus2.CPU_WE = 0; bus2.CPU_SEG = 5'h01; bus2.CPU_A = 14'h0200;
    sbq.push_back('{owner: 1'b0, we: 1'b0, addr: 19'h04200, data: 8'h3C});
    @(posedge CLK); #1 bus2.CPU_SEG = 5'h1F;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk("seg_hold", 32'(bus2.SRAM_A), 32'h04200);
    end
    @(posedge CLK); #1 bus2.CPU_REQ = 0;
    repeat (3) @(posedge CLK);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
